// File: rtl/cursor_pkg.sv
// Shared types for the cursor sequencer: FSM states, direction vector and helpers.
package cursor_pkg;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COMMIT, HOLD} state_t;

   // {up, down, left, right}, active-low
   typedef logic [3:0] dir_t;

   localparam int UP    = 3;
   localparam int DOWN  = 2;
   localparam int LEFT  = 1;
   localparam int RIGHT = 0;

   localparam dir_t RELEASED = 4'b1111;

   // Opposing pairs cancel to released; diagonals pass through.
   function automatic dir_t mask_opposing(input dir_t d);
      dir_t m;
      m = d;
      if (!d[UP] && !d[DOWN]) begin
         m[UP]   = 1'b1;
         m[DOWN] = 1'b1;
      end
      if (!d[LEFT] && !d[RIGHT]) begin
         m[LEFT]  = 1'b1;
         m[RIGHT] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a per-bit debouncer; idle (released) level is 1.
module btn_debounce #(
   parameter int W          = 5,
   parameter int DEB_CYCLES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] raw,
   output logic [W-1:0] sync,
   output logic [W-1:0] db
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   logic [W-1:0]         s1;
   logic [W-1:0][CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1   <= '1;
         sync <= '1;
         db   <= '1;
         cnt  <= '0;
      end else begin
         s1   <= raw;
         sync <= s1;
         for (int b = 0; b < W; b++) begin
            // any cycle agreeing with db restarts the bit's count
            if (sync[b] != db[b]) begin
               if (cnt[b] == CW'(DEB_CYCLES - 1)) begin
                  db[b]  <= sync[b];
                  cnt[b] <= '0;
               end else begin
                  cnt[b] <= cnt[b] + 1'b1;
               end
            end else begin
               cnt[b] <= '0;
            end
         end
      end
   end

endmodule

// File: rtl/cursor_ctrl.sv
// Cursor position owner and move sequencer for the 8x8 grid.
// Optional auto-repeat while a direction is held: define CURSOR_AUTOREPEAT_EN.
module cursor_ctrl
   import cursor_pkg::*;
#(
   parameter int GRID_BITS  = 3,
   parameter int DEB_CYCLES = 4,
   parameter int MOVE_LAT   = 1,
   parameter int START_I    = 0,
   parameter int START_J    = 0,
   parameter int RPT_DELAY  = 16,
   parameter int RPT_PERIOD = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 up_n,
   input  logic                 down_n,
   input  logic                 left_n,
   input  logic                 right_n,
   input  logic                 sel_n,
   output logic                 mv_up_n,
   output logic                 mv_down_n,
   output logic                 mv_left_n,
   output logic                 mv_right_n,
   output logic [GRID_BITS-1:0] cur_i,
   output logic [GRID_BITS-1:0] cur_j,
   input  logic [GRID_BITS-1:0] nxt_i,
   input  logic [GRID_BITS-1:0] nxt_j,
   input  logic                 mv_valid,
   output logic                 moved,
   output logic                 blocked,
   output logic                 sel_pulse,
   output logic                 busy
);

   logic [4:0] raw, sync, db;
   dir_t       dir, dir_m, prev_dir, dir_q, mv_q;
   logic       sel, sel_prev;
   state_t     state;
   logic [2:0] lat_cnt;
   logic [1:0] arm_cnt;
   logic       armed;
   logic       sample;

`ifdef CURSOR_AUTOREPEAT_EN
   localparam int RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);
   logic [RW-1:0] rpt_cnt;
   logic          rpt_first;
`endif

   assign raw = {up_n, down_n, left_n, right_n, sel_n};

   btn_debounce #(.W(5), .DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw),
      .sync (sync),
      .db   (db)
   );

   assign dir   = db[4:1];
   assign sel   = db[0];
   assign dir_m = mask_opposing(dir);

   assign {mv_up_n, mv_down_n, mv_left_n, mv_right_n} = mv_q;

   assign sample = (state == ISSUE && MOVE_LAT == 0) ||
                   (state == WAIT && lat_cnt == 3'(MOVE_LAT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         dir_q     <= RELEASED;
         mv_q      <= RELEASED;
         prev_dir  <= RELEASED;
         sel_prev  <= 1'b1;
         cur_i     <= GRID_BITS'(START_I);
         cur_j     <= GRID_BITS'(START_J);
         lat_cnt   <= '0;
         arm_cnt   <= '0;
         armed     <= 1'b0;
         moved     <= 1'b0;
         blocked   <= 1'b0;
         sel_pulse <= 1'b0;
         busy      <= 1'b0;
`ifdef CURSOR_AUTOREPEAT_EN
         rpt_cnt   <= '0;
         rpt_first <= 1'b1;
`endif
      end else begin
         prev_dir  <= dir;
         sel_prev  <= sel;
         moved     <= 1'b0;
         blocked   <= 1'b0;
         sel_pulse <= sel_prev & ~sel & (state == IDLE || state == HOLD);

         // A button still held through reset must be released before it can move
         // the cursor: arm only after every synchronised input reads released.
         if (&sync) begin
            if (arm_cnt == 2'd2) armed   <= 1'b1;
            else                 arm_cnt <= arm_cnt + 2'd1;
         end else begin
            arm_cnt <= '0;
         end

         case (state)
            IDLE: begin
               if (armed && dir != RELEASED && prev_dir == RELEASED) begin
                  dir_q <= dir_m;
`ifdef CURSOR_AUTOREPEAT_EN
                  rpt_cnt   <= '0;
                  rpt_first <= 1'b1;
`endif
                  if (dir_m != RELEASED) begin
                     state   <= ISSUE;
                     mv_q    <= dir_m;
                     busy    <= 1'b1;
                     lat_cnt <= '0;
                  end else begin
                     state <= HOLD;
                  end
               end
            end
            ISSUE: begin
               lat_cnt <= 3'd1;
               state   <= WAIT;
            end
            WAIT:   lat_cnt <= lat_cnt + 3'd1;
            COMMIT: begin
               busy  <= 1'b0;
               state <= HOLD;
            end
            HOLD: begin
               if (dir == RELEASED) begin
                  state <= IDLE;
               end
`ifdef CURSOR_AUTOREPEAT_EN
               else if (dir_m != dir_q || dir_q == RELEASED) begin
                  rpt_cnt   <= '0;
                  rpt_first <= 1'b1;
               end else if (rpt_cnt == RW'(rpt_first ? RPT_DELAY - 1 : RPT_PERIOD - 1)) begin
                  rpt_cnt   <= '0;
                  rpt_first <= 1'b0;
                  state     <= ISSUE;
                  mv_q      <= dir_q;
                  busy      <= 1'b1;
                  lat_cnt   <= '0;
               end else begin
                  rpt_cnt <= rpt_cnt + 1'b1;
               end
`endif
            end
            default: state <= IDLE;
         endcase

         // Sampling the movement block also commits, so moved/blocked show in COMMIT.
         if (sample) begin
            if (mv_valid) begin
               cur_i <= nxt_i;
               cur_j <= nxt_j;
               moved <= 1'b1;
            end else begin
               blocked <= 1'b1;
            end
            mv_q  <= RELEASED;
            state <= COMMIT;
         end
      end
   end

endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed bench for cursor_ctrl: table of single presses plus multi-cycle corner sequences.
module tb_cursor_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       up_n = 1'b1, down_n = 1'b1, left_n = 1'b1, right_n = 1'b1, sel_n = 1'b1;
   logic       mv_up_n, mv_down_n, mv_left_n, mv_right_n;
   logic [2:0] cur_i, cur_j;
   logic [2:0] ni = '0, nj = '0;
   logic       vld = 1'b0;
   logic       moved, blocked, sel_pulse, busy;

   int passed = 0;
   int total  = 0;

   int n_moved = 0, n_blk = 0, n_sel = 0, n_busy = 0, n_mvlow = 0;
   logic [3:0] mv_seen = 4'hf;

   cursor_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .up_n       (up_n),
      .down_n     (down_n),
      .left_n     (left_n),
      .right_n    (right_n),
      .sel_n      (sel_n),
      .mv_up_n    (mv_up_n),
      .mv_down_n  (mv_down_n),
      .mv_left_n  (mv_left_n),
      .mv_right_n (mv_right_n),
      .cur_i      (cur_i),
      .cur_j      (cur_j),
      .nxt_i      (ni),
      .nxt_j      (nj),
      .mv_valid   (vld),
      .moved      (moved),
      .blocked    (blocked),
      .sel_pulse  (sel_pulse),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (moved)     n_moved++;
      if (blocked)   n_blk++;
      if (sel_pulse) n_sel++;
      if (busy)      n_busy++;
      if ({mv_up_n, mv_down_n, mv_left_n, mv_right_n} != 4'hf) n_mvlow++;
      mv_seen &= {mv_up_n, mv_down_n, mv_left_n, mv_right_n};
   end

   typedef struct {
      string      name;
      logic [3:0] btn;     // {up,down,left,right} active-low
      logic [2:0] ni, nj;
      logic       v;
      int         e_moved, e_blk, e_busy, e_mvlow;
      logic [3:0] e_mv;
      logic [2:0] e_i, e_j;
   } vec_t;

   vec_t tbl[8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic run_row(input vec_t t);
      int m0, b0, bu0, ml0;
      ni = t.ni; nj = t.nj; vld = t.v;
      m0 = n_moved; b0 = n_blk; bu0 = n_busy; ml0 = n_mvlow;
      mv_seen = 4'hf;
      {up_n, down_n, left_n, right_n} = t.btn;
      repeat (20) step();
      {up_n, down_n, left_n, right_n} = 4'hf;
      repeat (12) step();
      chk({t.name, " moved"},   n_moved - m0, t.e_moved);
      chk({t.name, " blocked"}, n_blk - b0,   t.e_blk);
      chk({t.name, " busy"},    n_busy - bu0, t.e_busy);
      chk({t.name, " mvlow"},   n_mvlow - ml0, t.e_mvlow);
      chk({t.name, " mv"},      int'(mv_seen), int'(t.e_mv));
      chk({t.name, " cur_i"},   int'(cur_i),  int'(t.e_i));
      chk({t.name, " cur_j"},   int'(cur_j),  int'(t.e_j));
   endtask

   task automatic press_right(input logic [2:0] i, input logic [2:0] j);
      ni = i; nj = j; vld = 1'b1;
      right_n = 1'b0;
      repeat (20) step();
      right_n = 1'b1;
      repeat (12) step();
   endtask

   initial begin
      int m0, b0, s0, ml0;
      bit found;

      //           name      btn      ni    nj    v  mov blk bsy low mv       i     j
      tbl[0] = '{"right",   4'b1110, 3'd0, 3'd1, 1, 1,  0,  3,  2,  4'b1110, 3'd0, 3'd1};
      tbl[1] = '{"left",    4'b1101, 3'd0, 3'd0, 1, 1,  0,  3,  2,  4'b1101, 3'd0, 3'd0};
      tbl[2] = '{"up_blk",  4'b0111, 3'd7, 3'd0, 0, 0,  1,  3,  2,  4'b0111, 3'd0, 3'd0};
      tbl[3] = '{"to77",    4'b1110, 3'd7, 3'd7, 1, 1,  0,  3,  2,  4'b1110, 3'd7, 3'd7};
      tbl[4] = '{"diag",    4'b0101, 3'd6, 3'd6, 1, 1,  0,  3,  2,  4'b0101, 3'd6, 3'd6};
      tbl[5] = '{"updown",  4'b0011, 3'd1, 3'd1, 1, 0,  0,  0,  0,  4'b1111, 3'd6, 3'd6};
      tbl[6] = '{"ulr",     4'b0100, 3'd5, 3'd6, 1, 1,  0,  3,  2,  4'b0111, 3'd5, 3'd6};
      tbl[7] = '{"dn_blk",  4'b1011, 3'd0, 3'd0, 0, 0,  1,  3,  2,  4'b1011, 3'd5, 3'd6};

      // reset state
      repeat (3) step();
      chk("rst cur_i", int'(cur_i), 0);
      chk("rst cur_j", int'(cur_j), 0);
      chk("rst mv", int'({mv_up_n, mv_down_n, mv_left_n, mv_right_n}), 15);
      chk("rst moved", int'(moved), 0);
      chk("rst blocked", int'(blocked), 0);
      chk("rst sel_pulse", int'(sel_pulse), 0);
      chk("rst busy", int'(busy), 0);
      rst = 1'b1;
      repeat (10) step();

      for (int r = 0; r < 8; r++) run_row(tbl[r]);

      // latency: drive just after edge 0, debounced at edge 6, moved at edge 9
      ni = 3'd5; nj = 3'd7; vld = 1'b1;
      right_n = 1'b0;
      repeat (6) step();
      chk("lat mv before issue", int'(mv_right_n), 1);
      step();
      chk("lat mv at issue", int'(mv_right_n), 0);
      step();
      chk("lat moved at wait", int'(moved), 0);
      step();
      chk("lat moved at commit", int'(moved), 1);
      chk("lat cur_j", int'(cur_j), 7);
      chk("lat mv at commit", int'(mv_right_n), 1);
      step();
      chk("lat moved one cycle", int'(moved), 0);
      repeat (14) step();
      right_n = 1'b1;
      repeat (12) step();

      // bounce every 2 cycles never survives the debounce window
      ni = 3'd5; nj = 3'd6; vld = 1'b1;
      m0 = n_moved; ml0 = n_mvlow;
      for (int k = 0; k < 10; k++) begin
         right_n = k[0];
         repeat (2) step();
      end
      chk("bounce mvlow", n_mvlow - ml0, 0);
      chk("bounce moved", n_moved - m0, 0);
      right_n = 1'b0;
      repeat (20) step();
      right_n = 1'b1;
      repeat (12) step();
      chk("bounce steady moved", n_moved - m0, 1);
      chk("bounce cur_j", int'(cur_j), 6);

      // select alone
      s0 = n_sel; m0 = n_moved;
      sel_n = 1'b0;
      repeat (20) step();
      sel_n = 1'b1;
      repeat (12) step();
      chk("sel alone pulses", n_sel - s0, 1);
      chk("sel alone moved", n_moved - m0, 0);

      // select and direction together: both honoured
      s0 = n_sel; m0 = n_moved;
      ni = 3'd4; nj = 3'd6; vld = 1'b1;
      sel_n = 1'b0; up_n = 1'b0;
      repeat (20) step();
      sel_n = 1'b1; up_n = 1'b1;
      repeat (12) step();
      chk("sel+dir pulses", n_sel - s0, 1);
      chk("sel+dir moved", n_moved - m0, 1);
      chk("sel+dir cur_i", int'(cur_i), 4);

      // select edge landing in ISSUE is dropped
      s0 = n_sel; m0 = n_moved;
      ni = 3'd3; nj = 3'd6;
      up_n = 1'b0;
      step();
      sel_n = 1'b0;
      repeat (20) step();
      sel_n = 1'b1; up_n = 1'b1;
      repeat (12) step();
      chk("sel busy dropped", n_sel - s0, 0);
      chk("sel busy moved", n_moved - m0, 1);

      // reset during WAIT aborts the move; held button needs a fresh press
      ni = 3'd1; nj = 3'd1; vld = 1'b1;
      right_n = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         step();
         if (!mv_right_n) found = 1'b1;
      end
      chk("rstmid issue seen", int'(found), 1);
      step();
      rst = 1'b0;
      #1;
      m0 = n_moved; b0 = n_blk; ml0 = n_mvlow;
      mv_seen = 4'hf;
      chk("rstmid mv", int'({mv_up_n, mv_down_n, mv_left_n, mv_right_n}), 15);
      chk("rstmid cur_i", int'(cur_i), 0);
      chk("rstmid cur_j", int'(cur_j), 0);
      chk("rstmid busy", int'(busy), 0);
      repeat (3) step();
      rst = 1'b1;
      repeat (20) step();
      chk("rstmid held moved", n_moved - m0, 0);
      chk("rstmid held blocked", n_blk - b0, 0);
      chk("rstmid held mvlow", n_mvlow - ml0, 0);
      right_n = 1'b1;
      repeat (12) step();
      press_right(3'd0, 3'd1);
      chk("rstmid fresh moved", n_moved - m0, 1);
      chk("rstmid fresh cur_j", int'(cur_j), 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
